score_counter_bcd: RTL and testbench
====================================

# score_counter_bcd

Parametrised packed-BCD game score counter with pause, per-tick step, point prescaler, overflow policy and a high-score register. It sits between the game-control FSM, which supplies start/over pulses and the 60 Hz frame tick, and the score display/readout logic. It advances only on frame ticks while a game is running. At each game end it latches the best score seen since reset.

## Interface
- DIGITS, 4, number of BCD digits (1–8); score width 4*DIGITS
- TICKS_PER_POINT, 1, game_tick pulses per score increment (1–255)
- WRAP, 0, overflow policy: 0 saturates at all-9s, 1 wraps modulo 10^DIGITS
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- game_start  in  1  one-cycle pulse: clear score and start a game
- game_over  in  1  one-cycle pulse: end the game
- game_tick  in  1  one-cycle end-of-frame pulse, 60 Hz
- pause  in  1  level: freeze scoring while high
- step  in  4  BCD amount added per increment; values >9 are treated as 9
- score  out  4*DIGITS  current score, packed BCD, digit 0 = LSBs
- high_score  out  4*DIGITS  best final score since reset, packed BCD
- new_high  out  1  one-cycle pulse: high_score was just updated
- game_active  out  1  high in RUN or PAUSED
- overflow  out  1  sticky: score hit its limit during this game

## Operation
- FSM states: IDLE, RUN, PAUSED, OVER. Reset state is IDLE.
- game_start in any state → RUN. Same edge: score=0, prescaler=0, overflow=0. game_start has priority over game_over.
- RUN with pause=1 → PAUSED. PAUSED with pause=0 → RUN. Ticks are ignored in PAUSED and the prescaler holds its value.
- game_over in RUN or PAUSED → OVER. game_over in IDLE or OVER is ignored.
- On the game_over edge: if score > high_score, then high_score ← score and new_high=1 for the following cycle. Packed-BCD compare equals unsigned binary compare.
- In RUN, each game_tick increments the prescaler. When it reaches TICKS_PER_POINT−1 with a tick, it resets to 0 and score ← score + step (BCD, ripple carry digit by digit).
- If game_over and game_tick arrive on the same edge, the tick is discarded.
- Overflow, when carry-out from the top digit occurs:
  - WRAP=0: score=all-9s, overflow=1, no further change.
  - WRAP=1: score = sum mod 10^DIGITS, overflow=1.
- OVER and IDLE hold score unchanged.
- step=0 is legal and produces no change.
- Reset values: score=0, high_score=0, new_high=0, game_active=0, overflow=0. Reset may occur mid-game; it also clears high_score.

## Timing
- All outputs are registered.
- score updates on the clk edge that samples the qualifying game_tick, and is visible the next cycle. Latency is 1.
- game_active rises 1 cycle after game_start and falls 1 cycle after game_over.
- high_score and new_high are visible 1 cycle after game_over. new_high lasts exactly 1 cycle.
- The BCD add is combinational across all DIGITS in one cycle. No multicycle paths.

## Structure
- Shared package score_pkg holds:
  - state enum (IDLE, RUN, PAUSED, OVER), 2-bit encoding
  - BCD_MAX_DIGIT=4'd9
  - function bcd_clamp for step
- Sub-module bcd_digit_add: inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout. It is instantiated DIGITS times in a generate chain. b=step for digit 0, 0 for the others.
- Top level holds the FSM, prescaler, overflow policy and high-score logic.

## Test plan
- DIGITS=4: start, then 3 ticks with step=1 → score=16'h0003, game_active=1.
- Score 0099, step=1, one tick → 16'h0100. Step=12 from 0000 → 16'h0009.
- DIGITS=2, WRAP=0: score 98, step=5, tick → 8'h99, overflow=1; a further tick → still 8'h99. With WRAP=1 → 8'h03, overflow=1.
- TICKS_PER_POINT=6: 13 ticks with step=1 → score=0002. pause raised after tick 4 drops ticks 5–8; after resume, 6 more ticks → score=0003.
- Game ends at 0042 → high_score=0042 and a 1-cycle new_high pulse. Next game ends at 0030 → high_score stays 0042, no pulse. game_start and game_over on the same cycle → RUN, score=0.
- rst_n asserted mid-RUN at score 0017 → all outputs 0 immediately, FSM in IDLE, ticks ignored until game_start.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and helpers for the packed-BCD score counter.
package score_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      OVER   = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

   function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
      return (v > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : v;
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit of a ripple-carry decimal adder.
module bcd_digit_add
   import score_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] raw;

   always_comb begin
      raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      cout = (raw > {1'b0, BCD_MAX_DIGIT});
      sum  = cout ? 4'(raw - 5'd10) : raw[3:0];
   end

endmodule

// File: rtl/score_counter_bcd.sv
// Packed-BCD game score counter: game FSM, point prescaler, overflow policy, high-score latch.
//
// state  | meaning
// IDLE   | no game since reset; score held
// RUN    | game running; frame ticks advance the prescaler
// PAUSED | game running, scoring frozen, prescaler held
// OVER   | game ended; score held until next start
module score_counter_bcd #(
   parameter int DIGITS          = 4,
   parameter int TICKS_PER_POINT = 1,
   parameter bit WRAP            = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                game_start,
   input  logic                game_over,
   input  logic                game_tick,
   input  logic                pause,
   input  logic [3:0]          step,
   output logic [4*DIGITS-1:0] score,
   output logic [4*DIGITS-1:0] high_score,
   output logic                new_high,
   output logic                game_active,
   output logic                overflow
);
   import score_pkg::*;

   localparam int            SW        = 4*DIGITS;
   localparam logic [SW-1:0] ALL_NINES = {DIGITS{BCD_MAX_DIGIT}};
   localparam logic [7:0]    TPP_LAST  = 8'(TICKS_PER_POINT - 1);

   state_t          state;
   logic [7:0]      presc;
   logic [3:0]      step_c;
   logic [SW-1:0]   sum;
   logic [DIGITS:0] carry;

   assign step_c   = bcd_clamp(step);
   assign carry[0] = 1'b0;

   // step enters at digit 0 only; higher digits just absorb the ripple carry
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] b_dig;
      assign b_dig = (i == 0) ? step_c : 4'd0;
      bcd_digit_add u_add (
         .a    (score[4*i +: 4]),
         .b    (b_dig),
         .cin  (carry[i]),
         .sum  (sum[4*i +: 4]),
         .cout (carry[i+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         presc       <= '0;
         score       <= '0;
         high_score  <= '0;
         new_high    <= 1'b0;
         game_active <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         new_high <= 1'b0;
         if (game_start) begin
            state       <= RUN;
            presc       <= '0;
            score       <= '0;
            overflow    <= 1'b0;
            game_active <= 1'b1;
         end else if (game_over && (state == RUN || state == PAUSED)) begin
            state       <= OVER;
            game_active <= 1'b0;
            if (score > high_score) begin
               high_score <= score;
               new_high   <= 1'b1;
            end
         end else begin
            case (state)
               RUN: begin
                  if (pause) begin
                     state <= PAUSED;
                  end else if (game_tick) begin
                     if (presc == TPP_LAST) begin
                        presc <= '0;
                        if (carry[DIGITS]) begin
                           overflow <= 1'b1;
                           score    <= WRAP ? sum : ALL_NINES;
                        end else begin
                           score <= sum;
                        end
                     end else begin
                        presc <= presc + 8'd1;
                     end
                  end
               end
               PAUSED: begin
                  if (!pause) state <= RUN;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_score_counter_bcd.sv
// Bench for score_counter_bcd: four configurations share stimulus against a decimal reference model.
module tb_score_counter_bcd;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       game_start, game_over, game_tick, pause;
   logic [3:0] step;

   logic [15:0] sc0, hs0, sc3, hs3;
   logic [7:0]  sc1, hs1, sc2, hs2;
   logic        nh0, nh1, nh2, nh3, ga0, ga1, ga2, ga3, ov0, ov1, ov2, ov3;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   score_counter_bcd #(.DIGITS(4), .TICKS_PER_POINT(1), .WRAP(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .game_start(game_start), .game_over(game_over),
      .game_tick(game_tick), .pause(pause), .step(step), .score(sc0),
      .high_score(hs0), .new_high(nh0), .game_active(ga0), .overflow(ov0));
   score_counter_bcd #(.DIGITS(2), .TICKS_PER_POINT(1), .WRAP(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .game_start(game_start), .game_over(game_over),
      .game_tick(game_tick), .pause(pause), .step(step), .score(sc1),
      .high_score(hs1), .new_high(nh1), .game_active(ga1), .overflow(ov1));
   score_counter_bcd #(.DIGITS(2), .TICKS_PER_POINT(1), .WRAP(1'b1)) u2 (
      .clk(clk), .rst_n(rst_n), .game_start(game_start), .game_over(game_over),
      .game_tick(game_tick), .pause(pause), .step(step), .score(sc2),
      .high_score(hs2), .new_high(nh2), .game_active(ga2), .overflow(ov2));
   score_counter_bcd #(.DIGITS(4), .TICKS_PER_POINT(6), .WRAP(1'b1)) u3 (
      .clk(clk), .rst_n(rst_n), .game_start(game_start), .game_over(game_over),
      .game_tick(game_tick), .pause(pause), .step(step), .score(sc3),
      .high_score(hs3), .new_high(nh3), .game_active(ga3), .overflow(ov3));

   logic [31:0] d_score [4];
   logic [31:0] d_high  [4];
   logic        d_nh [4], d_ga [4], d_ov [4];
   assign d_score[0] = 32'(sc0); assign d_score[1] = 32'(sc1);
   assign d_score[2] = 32'(sc2); assign d_score[3] = 32'(sc3);
   assign d_high[0]  = 32'(hs0); assign d_high[1]  = 32'(hs1);
   assign d_high[2]  = 32'(hs2); assign d_high[3]  = 32'(hs3);
   assign d_nh[0] = nh0; assign d_nh[1] = nh1; assign d_nh[2] = nh2; assign d_nh[3] = nh3;
   assign d_ga[0] = ga0; assign d_ga[1] = ga1; assign d_ga[2] = ga2; assign d_ga[3] = ga3;
   assign d_ov[0] = ov0; assign d_ov[1] = ov1; assign d_ov[2] = ov2; assign d_ov[3] = ov3;

   localparam int P_D [4] = '{4, 2, 2, 4};
   localparam int P_T [4] = '{1, 1, 1, 6};
   localparam int P_W [4] = '{0, 0, 1, 1};
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_OVER = 3;

   // reference model: scores held as plain decimal integers
   int m_st [4], m_score [4], m_high [4], m_presc [4];
   bit m_newh [4], m_ovf [4];

   function automatic int pow10(input int d);
      int r = 1;
      repeat (d) r = r * 10;
      return r;
   endfunction

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r = '0;
      int x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            m_st[k] = M_IDLE; m_score[k] = 0; m_high[k] = 0; m_presc[k] = 0;
            m_newh[k] = 1'b0; m_ovf[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            int lim, s;
            m_newh[k] = 1'b0;
            lim = pow10(P_D[k]);
            if (game_start) begin
               m_st[k] = M_RUN; m_score[k] = 0; m_presc[k] = 0; m_ovf[k] = 1'b0;
            end else if (game_over && (m_st[k] == M_RUN || m_st[k] == M_PAUSED)) begin
               m_st[k] = M_OVER;
               if (m_score[k] > m_high[k]) begin
                  m_high[k] = m_score[k];
                  m_newh[k] = 1'b1;
               end
            end else if (m_st[k] == M_RUN) begin
               if (pause) m_st[k] = M_PAUSED;
               else if (game_tick) begin
                  m_presc[k]++;
                  if (m_presc[k] == P_T[k]) begin
                     m_presc[k] = 0;
                     s = m_score[k] + ((step > 4'd9) ? 9 : int'(step));
                     if (s >= lim) begin
                        m_ovf[k] = 1'b1;
                        m_score[k] = (P_W[k] != 0) ? s - lim : lim - 1;
                     end else begin
                        m_score[k] = s;
                     end
                  end
               end
            end else if (m_st[k] == M_PAUSED && !pause) begin
               m_st[k] = M_RUN;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         check($sformatf("score[%0d]", k), d_score[k], to_bcd(m_score[k]));
         check($sformatf("high_score[%0d]", k), d_high[k], to_bcd(m_high[k]));
         check($sformatf("new_high[%0d]", k), 32'(d_nh[k]), 32'(m_newh[k]));
         check($sformatf("game_active[%0d]", k), 32'(d_ga[k]),
               32'(m_st[k] == M_RUN || m_st[k] == M_PAUSED));
         check($sformatf("overflow[%0d]", k), 32'(d_ov[k]), 32'(m_ovf[k]));
      end
   end

   task automatic clk_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      game_start = 1'b1; clk_cycle(); game_start = 1'b0;
   endtask

   task automatic pulse_over();
      game_over = 1'b1; clk_cycle(); game_over = 1'b0;
   endtask

   task automatic ticks(input int n, input logic [3:0] s);
      step = s;
      repeat (n) begin
         game_tick = 1'b1; clk_cycle(); game_tick = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0; game_start = 1'b0; game_over = 1'b0; game_tick = 1'b0;
      pause = 1'b0; step = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset score", 32'(sc0), 32'h0);
      check("reset active", 32'(ga0), 32'h0);
      rst_n = 1'b1;
      clk_cycle();

      pulse_start();
      ticks(3, 4'd1);
      check("three ticks", 32'(sc0), 32'h0003);
      check("active in run", 32'(ga0), 32'h1);

      pulse_start();
      ticks(11, 4'd9);
      check("reach 0099", 32'(sc0), 32'h0099);
      ticks(1, 4'd1);
      check("carry to 0100", 32'(sc0), 32'h0100);
      check("2dig sat at 99", 32'(sc1), 32'h99);
      check("2dig sat ovf", 32'(ov1), 32'h1);
      check("2dig wrap to 00", 32'(sc2), 32'h00);

      pulse_start();
      ticks(1, 4'd12);
      check("step clamp 12", 32'(sc0), 32'h0009);

      pulse_start();
      ticks(10, 4'd9);
      ticks(1, 4'd8);
      check("2dig at 98", 32'(sc1), 32'h98);
      check("no ovf yet", 32'(ov1), 32'h0);
      ticks(1, 4'd5);
      check("sat 98+5", 32'(sc1), 32'h99);
      check("sat ovf", 32'(ov1), 32'h1);
      check("wrap 98+5", 32'(sc2), 32'h03);
      check("wrap ovf", 32'(ov2), 32'h1);
      ticks(1, 4'd5);
      check("sat holds", 32'(sc1), 32'h99);

      pulse_start();
      ticks(13, 4'd1);
      check("tpp6 13 ticks", 32'(sc3), 32'h0002);
      ticks(4, 4'd1);
      pause = 1'b1;
      clk_cycle();
      ticks(4, 4'd1);
      check("paused ticks dropped", 32'(sc3), 32'h0002);
      check("active while paused", 32'(ga3), 32'h1);
      pause = 1'b0;
      clk_cycle();
      ticks(6, 4'd1);
      check("tpp6 after resume", 32'(sc3), 32'h0003);

      pulse_start();
      ticks(4, 4'd9);
      ticks(1, 4'd6);
      check("score 0042", 32'(sc0), 32'h0042);
      pulse_over();
      check("high 0042", 32'(hs0), 32'h0042);
      check("new_high pulse", 32'(nh0), 32'h1);
      check("inactive after over", 32'(ga0), 32'h0);
      clk_cycle();
      check("new_high one cycle", 32'(nh0), 32'h0);

      pulse_start();
      ticks(3, 4'd9);
      ticks(1, 4'd3);
      check("score 0030", 32'(sc0), 32'h0030);
      pulse_over();
      check("high kept 0042", 32'(hs0), 32'h0042);
      check("no new_high", 32'(nh0), 32'h0);

      game_start = 1'b1; game_over = 1'b1;
      clk_cycle();
      game_start = 1'b0; game_over = 1'b0;
      check("start wins active", 32'(ga0), 32'h1);
      check("start wins score", 32'(sc0), 32'h0);

      ticks(1, 4'd9);
      ticks(1, 4'd8);
      check("score 0017", 32'(sc0), 32'h0017);
      #2 rst_n = 1'b0;
      #1;
      check("async rst score", 32'(sc0), 32'h0);
      check("async rst high", 32'(hs0), 32'h0);
      check("async rst active", 32'(ga0), 32'h0);
      clk_cycle();
      rst_n = 1'b1;
      ticks(3, 4'd1);
      check("idle ignores ticks", 32'(sc0), 32'h0);
      check("idle inactive", 32'(ga0), 32'h0);

      repeat (3000) begin
         game_start = ($urandom_range(0, 63) == 0);
         game_over  = ($urandom_range(0, 39) == 0);
         game_tick  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) pause = ~pause;
         step = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 999) == 0) begin
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         clk_cycle();
      end
      game_start = 1'b0; game_over = 1'b0; game_tick = 1'b0; pause = 1'b0;
      repeat (3) clk_cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
